// File: rtl/kbd_pkg.sv
// Shared constants, prefix FSM state encoding and queue entry layout for the
// PS/2 scancode queue.
package kbd_pkg;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_REL = 8'hF0;
  localparam int         KBD_ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_REL,
    ST_EXTREL
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_entry_t;

  function automatic logic kbd_is_prefix(input logic [7:0] b);
    return (b == KBD_PFX_EXT) || (b == KBD_PFX_REL);
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Parameterized synchronous FIFO with flush, occupancy count and a
// combinational head read at the read pointer.
module kbd_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_eff;
  logic          push_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A pop on empty is ignored; a push into a full FIFO only lands when a pop
  // frees the head slot in the same cycle.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + AW'(1);
      if (pop_eff)  rptr_d = rptr_q + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_eff && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/kbd_queue.sv
// PS/2 scancode queue: folds E0/F0 prefixes into per-key flags, buffers keys
// in a FIFO for the CPU and toggles an interrupt per queued key.
module kbd_queue
  import kbd_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_hit,
  input  logic [7:0]  ps2_data,
  input  logic        rd,
  input  logic        clr,
  output logic [7:0]  kb_data,
  output logic [1:0]  kb_flags,
  output logic [AW:0] kb_count,
  output logic        kb_ovf,
  output logic        kb_intr
);

  kbd_state_e state_q, state_d;
  logic       ovf_q, ovf_d;
  logic       intr_q, intr_d;
  logic       key_done;
  logic       cur_ext;
  logic       cur_rel;
  logic       key_accept;
  logic       key_drop;
  kbd_entry_t new_entry;
  kbd_entry_t head_entry;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (ps2_hit) begin
      if (ps2_data == KBD_PFX_EXT) begin
        case (state_q)
          ST_IDLE: state_d = ST_EXT;
          ST_REL:  state_d = ST_EXTREL;
          default: state_d = state_q;
        endcase
      end else if (ps2_data == KBD_PFX_REL) begin
        case (state_q)
          ST_IDLE: state_d = ST_REL;
          ST_EXT:  state_d = ST_EXTREL;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    key_done = ps2_hit && !kbd_is_prefix(ps2_data);
    cur_ext  = (state_q == ST_EXT) || (state_q == ST_EXTREL);
    cur_rel  = (state_q == ST_REL) || (state_q == ST_EXTREL);
  end

  assign new_entry = '{ext: cur_ext, rel: cur_rel, code: ps2_data};

  // Mirrors the FIFO's own accept rule; a full FIFO is never empty, so rd
  // always frees a slot there. clr discards the incoming byte outright.
  assign key_accept = key_done && !clr && (!fifo_full || rd);
  assign key_drop   = key_done && !clr && fifo_full && !rd;

  always_comb begin
    ovf_d  = ovf_q;
    intr_d = intr_q;
    if (clr)           ovf_d = 1'b0;
    else if (key_drop) ovf_d = 1'b1;
    if (key_accept)    intr_d = !intr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      intr_q <= intr_d;
    end
  end

  kbd_fifo #(
    .DEPTH (DEPTH),
    .W     (KBD_ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (key_done),
    .pop_i   (rd),
    .flush_i (clr),
    .wdata_i (new_entry),
    .head_o  (head_entry),
    .count_o (kb_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kb_data  = fifo_empty ? 8'h00 : head_entry.code;
  assign kb_flags = fifo_empty ? 2'b00 : {head_entry.ext, head_entry.rel};
  assign kb_ovf   = ovf_q;
  assign kb_intr  = intr_q;

endmodule

// File: tb/tb_kbd_queue.sv
// Directed self-checking bench for kbd_queue: prefix folding, overflow,
// simultaneous push/pop, flush priority and reset mid-prefix.
module tb_kbd_queue;

  logic       clock;
  logic       reset;
  logic       ps2_hit;
  logic [7:0] ps2_data;
  logic       rd;
  logic       clr;
  logic [7:0] kb_data;
  logic [1:0] kb_flags;
  logic [4:0] kb_count;
  logic       kb_ovf;
  logic       kb_intr;

  int checks;
  int fails;

  kbd_queue #(.DEPTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_hit  (ps2_hit),
    .ps2_data (ps2_data),
    .rd       (rd),
    .clr      (clr),
    .kb_data  (kb_data),
    .kb_flags (kb_flags),
    .kb_count (kb_count),
    .kb_ovf   (kb_ovf),
    .kb_intr  (kb_intr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic hit, input logic [7:0] data,
                               input logic pop, input logic flush);
    ps2_hit  = hit;
    ps2_data = data;
    rd       = pop;
    clr      = flush;
    tick();
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [7:0] d, input logic [1:0] f,
                           input logic [4:0] c);
    checkOutput({tag, "_data"}, 32'(kb_data), 32'(d));
    checkOutput({tag, "_flags"}, 32'(kb_flags), 32'(f));
    checkOutput({tag, "_count"}, 32'(kb_count), 32'(c));
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    reset    = 1'b1;
    ps2_hit  = 1'b0;
    ps2_data = 8'h00;
    rd       = 1'b0;
    clr      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    checkHead("rst", 8'h00, 2'b00, 5'd0);
    checkOutput("rst_ovf", 32'(kb_ovf), 32'd0);
    checkOutput("rst_intr", 32'(kb_intr), 32'd0);

    // Plain key
    applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
    checkHead("key1c", 8'h1C, 2'b00, 5'd1);
    checkOutput("key1c_intr", 32'(kb_intr), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkHead("pop1c", 8'h00, 2'b00, 5'd0);

    // Extended release E0 F0 75
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    checkOutput("pfx_e0_count", 32'(kb_count), 32'd0);
    checkOutput("pfx_e0_intr", 32'(kb_intr), 32'd1);
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
    checkOutput("pfx_f0_count", 32'(kb_count), 32'd0);
    checkOutput("pfx_f0_intr", 32'(kb_intr), 32'd1);
    applyStimulus(1'b1, 8'h75, 1'b0, 1'b0);
    checkHead("extrel75", 8'h75, 2'b11, 5'd1);
    checkOutput("extrel75_intr", 32'(kb_intr), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkHead("clr1", 8'h00, 2'b00, 5'd0);
    checkOutput("clr1_intr", 32'(kb_intr), 32'd0);

    // Repeated E0 stays EXT
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    checkHead("ext12", 8'h12, 2'b10, 5'd1);
    checkOutput("ext12_intr", 32'(kb_intr), 32'd1);

    // clr wins over a simultaneous key
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkHead("clrhit", 8'h00, 2'b00, 5'd0);
    checkOutput("clrhit_intr", 32'(kb_intr), 32'd1);

    // Fill, then overflow
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkHead("full", 8'h01, 2'b00, 5'd16);
    checkOutput("full_intr", 32'(kb_intr), 32'd1);
    checkOutput("full_ovf", 32'(kb_ovf), 32'd0);
    applyStimulus(1'b1, 8'h2A, 1'b0, 1'b0);
    checkHead("drop", 8'h01, 2'b00, 5'd16);
    checkOutput("drop_ovf", 32'(kb_ovf), 32'd1);
    checkOutput("drop_intr", 32'(kb_intr), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkHead("clr2", 8'h00, 2'b00, 5'd0);
    checkOutput("clr2_ovf", 32'(kb_ovf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    checkHead("fullpp", 8'h02, 2'b00, 5'd16);
    checkOutput("fullpp_ovf", 32'(kb_ovf), 32'd0);
    checkOutput("fullpp_intr", 32'(kb_intr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_head", 32'(kb_data), (i < 15) ? 32'(i + 2) : 32'h33);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkHead("drained", 8'h00, 2'b00, 5'd0);

    // Pop on empty is ignored
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkHead("emptypop", 8'h00, 2'b00, 5'd0);

    // Order preserved
    applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    checkHead("q3", 8'h1C, 2'b00, 5'd3);
    checkOutput("q3_intr", 32'(kb_intr), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkHead("q3pop1", 8'h32, 2'b00, 5'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkHead("q3pop2", 8'h21, 2'b00, 5'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkHead("q3pop3", 8'h00, 2'b00, 5'd0);

    // Push and pop together while empty: push takes effect
    applyStimulus(1'b1, 8'h4B, 1'b1, 1'b0);
    checkHead("emptypp", 8'h4B, 2'b00, 5'd1);
    checkOutput("emptypp_intr", 32'(kb_intr), 32'd0);

    // Reset mid-prefix discards the E0
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkHead("rst2", 8'h00, 2'b00, 5'd0);
    applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
    checkHead("postrst", 8'h1C, 2'b00, 5'd1);
    checkOutput("postrst_intr", 32'(kb_intr), 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
